// File: rtl/bcd_stopwatch_lap.sv
// bcd_stopwatch_lap: six-digit MM:SS.hh BCD stopwatch with tick prescaler,
// up/down counting, validated preset load, wrap/zero flags and a lap FIFO.
// Digit index 0 is tens-ms (bits 3:0), index 5 is tens-min (bits 23:20).
module bcd_stopwatch_lap #(
  parameter int TICK_DIV  = 2,
  parameter int LAP_DEPTH = 4
) (
  input  logic                           i_rtcclk,
  input  logic                           i_reset,
  input  logic                           i_countenb,
  input  logic                           i_countinit,
  input  logic                           i_updown,
  input  logic                           i_load,
  input  logic [23:0]                    i_load_value,
  input  logic                           i_lap,
  input  logic                           i_lap_ready,
  output logic [23:0]                    o_count,
  output logic                           o_zero,
  output logic                           o_wrap,
  output logic                           o_load_err,
  output logic                           o_lap_valid,
  output logic [23:0]                    o_lap_count,
  output logic [$clog2(LAP_DEPTH+1)-1:0] o_lap_level,
  output logic                           o_lap_full,
  output logic                           o_lap_ovf
);

  localparam int LW = $clog2(LAP_DEPTH + 1);
  localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(LAP_DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(LAP_DEPTH);
  localparam logic [23:0]   CNT_MAX  = 24'h595999;

  // Tens-of-seconds and tens-of-minutes digits run 0-5, all others 0-9.
  function automatic logic [3:0] digit_max(input int idx);
    return ((idx == 3) || (idx == 5)) ? 4'd5 : 4'd9;
  endfunction

  // Every digit must lie inside its own range for a preset to be accepted.
  function automatic logic bcd_valid(input logic [23:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ok = ok & (v[i*4 +: 4] <= digit_max(i));
    end
    return ok;
  endfunction

  // Ripple increment; a digit at its maximum rolls to 0 and carries on.
  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == digit_max(i)) begin
          r[i*4 +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // Ripple decrement; a digit at 0 reloads its maximum and borrows on.
  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = digit_max(i);
          borrow      = 1'b1;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // Lap pointers wrap at the buffer depth, which need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  logic [23:0]   r_count;
  logic [PW-1:0] r_presc;
  logic          r_wrap;
  logic          r_load_err;
  logic [23:0]   r_mem [LAP_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [LW-1:0] r_level;
  logic          r_lap_valid;
  logic          r_lap_full;
  logic          r_lap_ovf;
  logic [23:0]   r_lap_out;

  logic          w_adv;
  logic          w_load_ok;
  logic [23:0]   w_count_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic          w_wrap_nxt;
  logic          w_err_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_mem_we;
  logic [LW-1:0] w_remain;
  logic [LW-1:0] w_level_nxt;
  logic [AW-1:0] w_rd_nxt;
  logic [AW-1:0] w_wr_nxt;
  logic [23:0]   w_head_nxt;
  logic          w_ovf_nxt;

  // Count path: clear beats load, load (good or bad) beats an advance.
  always_comb begin
    w_adv       = i_countenb && (r_presc == PRE_LAST);
    w_load_ok   = i_load && bcd_valid(i_load_value);
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (i_countinit) begin
      w_count_nxt = 24'd0;
    end else if (i_load) begin
      if (w_load_ok) begin
        w_count_nxt = i_load_value;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (w_adv) begin
      if (i_updown) begin
        w_count_nxt = bcd_inc(r_count);
        w_wrap_nxt  = (r_count == CNT_MAX);
      end else if (r_count != 24'd0) begin
        w_count_nxt = bcd_dec(r_count);
      end else begin
        w_count_nxt = r_count;
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Prescaler: free-runs while enabled, restarts on clear or accepted load.
  always_comb begin
    w_presc_nxt = r_presc;
    if (i_countinit || w_load_ok) begin
      w_presc_nxt = {PW{1'b0}};
    end else if (i_countenb) begin
      w_presc_nxt = w_adv ? {PW{1'b0}} : r_presc + PW'(1);
    end else begin
      w_presc_nxt = r_presc;
    end
  end

  // Lap FIFO control: pop frees a slot for a same-cycle push even when full.
  always_comb begin
    w_pop       = r_lap_valid && i_lap_ready;
    w_push      = i_lap && ((r_level != LVL_FULL) || w_pop);
    w_drop      = i_lap && (r_level == LVL_FULL) && !w_pop;
    w_mem_we    = w_push && !i_countinit;
    w_remain    = r_level - LW'(w_pop);
    w_level_nxt = w_remain + LW'(w_push);
    w_rd_nxt    = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_wr_nxt    = w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_ovf_nxt   = r_lap_ovf | w_drop;
    w_head_nxt  = 24'd0;
    if (i_countinit) begin
      w_level_nxt = {LW{1'b0}};
      w_rd_nxt    = {AW{1'b0}};
      w_wr_nxt    = {AW{1'b0}};
      w_ovf_nxt   = 1'b0;
      w_head_nxt  = 24'd0;
    end else if (w_level_nxt == {LW{1'b0}}) begin
      w_head_nxt = 24'd0;
    end else if (w_remain == {LW{1'b0}}) begin
      w_head_nxt = r_count;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // State register for count, prescaler, pulses and lap bookkeeping.
  always_ff @(posedge i_rtcclk or posedge i_reset) begin
    if (i_reset) begin
      r_count     <= 24'd0;
      r_presc     <= {PW{1'b0}};
      r_wrap      <= 1'b0;
      r_load_err  <= 1'b0;
      r_rd_ptr    <= {AW{1'b0}};
      r_wr_ptr    <= {AW{1'b0}};
      r_level     <= {LW{1'b0}};
      r_lap_valid <= 1'b0;
      r_lap_full  <= 1'b0;
      r_lap_ovf   <= 1'b0;
      r_lap_out   <= 24'd0;
    end else begin
      r_count     <= w_count_nxt;
      r_presc     <= w_presc_nxt;
      r_wrap      <= w_wrap_nxt;
      r_load_err  <= w_err_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_wr_ptr    <= w_wr_nxt;
      r_level     <= w_level_nxt;
      r_lap_valid <= (w_level_nxt != {LW{1'b0}});
      r_lap_full  <= (w_level_nxt == LVL_FULL);
      r_lap_ovf   <= w_ovf_nxt;
      r_lap_out   <= w_head_nxt;
    end
  end

  // Lap storage captures the pre-advance count; contents need no reset.
  always_ff @(posedge i_rtcclk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr] <= r_count;
    end
  end

  assign o_count     = r_count;
  assign o_zero      = (r_count == 24'd0);
  assign o_wrap      = r_wrap;
  assign o_load_err  = r_load_err;
  assign o_lap_valid = r_lap_valid;
  assign o_lap_count = r_lap_out;
  assign o_lap_level = r_level;
  assign o_lap_full  = r_lap_full;
  assign o_lap_ovf   = r_lap_ovf;

endmodule

// File: tb/tb_bcd_stopwatch_lap.sv
// Bench for bcd_stopwatch_lap: two instances (TICK_DIV 2 and 1) share inputs;
// a time-in-hundredths model predicts both, plus literal pins per scenario.
module tb_bcd_stopwatch_lap;

  logic        clk = 1'b0;
  logic        i_reset, i_countenb, i_countinit, i_updown, i_load, i_lap, i_lap_ready;
  logic [23:0] i_load_value;

  logic [23:0] o0_count, o0_lap_count, o1_count, o1_lap_count;
  logic [2:0]  o0_lap_level, o1_lap_level;
  logic        o0_zero, o0_wrap, o0_load_err, o0_lap_valid, o0_lap_full, o0_lap_ovf;
  logic        o1_zero, o1_wrap, o1_load_err, o1_lap_valid, o1_lap_full, o1_lap_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_stopwatch_lap #(.TICK_DIV(2), .LAP_DEPTH(4)) u_dut0 (
    .i_rtcclk(clk), .i_reset(i_reset), .i_countenb(i_countenb), .i_countinit(i_countinit),
    .i_updown(i_updown), .i_load(i_load), .i_load_value(i_load_value), .i_lap(i_lap),
    .i_lap_ready(i_lap_ready), .o_count(o0_count), .o_zero(o0_zero), .o_wrap(o0_wrap),
    .o_load_err(o0_load_err), .o_lap_valid(o0_lap_valid), .o_lap_count(o0_lap_count),
    .o_lap_level(o0_lap_level), .o_lap_full(o0_lap_full), .o_lap_ovf(o0_lap_ovf));

  bcd_stopwatch_lap #(.TICK_DIV(1), .LAP_DEPTH(4)) u_dut1 (
    .i_rtcclk(clk), .i_reset(i_reset), .i_countenb(i_countenb), .i_countinit(i_countinit),
    .i_updown(i_updown), .i_load(i_load), .i_load_value(i_load_value), .i_lap(i_lap),
    .i_lap_ready(i_lap_ready), .o_count(o1_count), .o_zero(o1_zero), .o_wrap(o1_wrap),
    .o_load_err(o1_load_err), .o_lap_valid(o1_lap_valid), .o_lap_count(o1_lap_count),
    .o_lap_level(o1_lap_level), .o_lap_full(o1_lap_full), .o_lap_ovf(o1_lap_ovf));

  // ---------------- model: time held as an integer number of hundredths
  localparam int DEPTH = 4;
  localparam int TMAX  = 359999;
  int          m_tdiv [2] = '{2, 1};
  int          m_cnt  [2];
  int          m_pre  [2];
  bit          m_wrap [2];
  bit          m_err  [2];
  bit          m_ovf  [2];
  logic [23:0] m_q0[$];
  logic [23:0] m_q1[$];

  function automatic logic [23:0] to_bcd(input int n);
    int h, s, m;
    h = n % 100;
    s = (n / 100) % 60;
    m = n / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [23:0] v);
    return (v[23:20] <= 4'd5) && (v[19:16] <= 4'd9) && (v[15:12] <= 4'd5) &&
           (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic int from_bcd(input logic [23:0] v);
    return (int'(v[23:20]) * 10 + int'(v[19:16])) * 6000 +
           (int'(v[15:12]) * 10 + int'(v[11:8])) * 100 +
           int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_wrap[k] = 1'b0; m_err[k] = 1'b0; m_ovf[k] = 1'b0;
    end
    m_q0.delete();
    m_q1.delete();
  endtask

  task automatic model_step(input int k);
    logic [23:0] q[$];
    bit adv;
    if (k == 0) q = m_q0; else q = m_q1;
    m_wrap[k] = 1'b0;
    m_err[k]  = 1'b0;
    if (i_countinit) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_ovf[k] = 1'b0;
      q.delete();
    end else begin
      adv = i_countenb && (m_pre[k] == m_tdiv[k] - 1);
      if ((q.size() > 0) && i_lap_ready) void'(q.pop_front());
      if (i_lap) begin
        if (q.size() < DEPTH) q.push_back(to_bcd(m_cnt[k]));
        else m_ovf[k] = 1'b1;
      end
      if (i_load && bcd_ok(i_load_value)) begin
        m_cnt[k] = from_bcd(i_load_value);
        m_pre[k] = 0;
      end else begin
        if (i_load) m_err[k] = 1'b1;
        else if (adv && i_updown) begin
          m_wrap[k] = (m_cnt[k] == TMAX);
          m_cnt[k]  = (m_cnt[k] == TMAX) ? 0 : m_cnt[k] + 1;
        end else if (adv && (m_cnt[k] > 0)) m_cnt[k] = m_cnt[k] - 1;
        if (i_countenb) m_pre[k] = (m_pre[k] + 1) % m_tdiv[k];
      end
    end
    if (k == 0) m_q0 = q; else m_q1 = q;
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h expected=%h", name, k, act, exp);
    end
  endtask

  task automatic check_one(input int k, input logic [23:0] cnt, input logic zero, input logic wrap,
                           input logic err, input logic lv, input logic [23:0] lc,
                           input logic [2:0] ll, input logic lf, input logic lo);
    logic [23:0] q[$];
    if (k == 0) q = m_q0; else q = m_q1;
    chk("count", k, 32'(cnt), 32'(to_bcd(m_cnt[k])));
    chk("zero", k, 32'(zero), 32'(m_cnt[k] == 0));
    chk("wrap", k, 32'(wrap), 32'(m_wrap[k]));
    chk("load_err", k, 32'(err), 32'(m_err[k]));
    chk("lap_valid", k, 32'(lv), 32'(q.size() > 0));
    chk("lap_count", k, 32'(lc), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk("lap_level", k, 32'(ll), 32'(q.size()));
    chk("lap_full", k, 32'(lf), 32'(q.size() == DEPTH));
    chk("lap_ovf", k, 32'(lo), 32'(m_ovf[k]));
  endtask

  // One clock: advance model with pre-edge inputs, then compare on the falling edge.
  task automatic cycle();
    if (i_reset) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    @(posedge clk);
    @(negedge clk);
    check_one(0, o0_count, o0_zero, o0_wrap, o0_load_err, o0_lap_valid, o0_lap_count,
              o0_lap_level, o0_lap_full, o0_lap_ovf);
    check_one(1, o1_count, o1_zero, o1_wrap, o1_load_err, o1_lap_valid, o1_lap_count,
              o1_lap_level, o1_lap_full, o1_lap_ovf);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    i_reset = 1'b1; i_countenb = 1'b0; i_countinit = 1'b0; i_updown = 1'b1;
    i_load = 1'b0; i_load_value = 24'd0; i_lap = 1'b0; i_lap_ready = 1'b0;
    cycles(2);
    chk("pin_rst_count", 0, 32'(o0_count), 32'h0);
    chk("pin_rst_zero", 0, 32'(o0_zero), 32'd1);
    chk("pin_rst_level", 1, 32'(o1_lap_level), 32'd0);
    i_reset = 1'b0;

    // Up count from reset
    i_countenb = 1'b1; i_updown = 1'b1;
    cycles(2);
    chk("pin_up2", 0, 32'(o0_count), 32'h000001);
    chk("pin_up2", 1, 32'(o1_count), 32'h000002);
    cycles(198);
    chk("pin_up200", 0, 32'(o0_count), 32'h000100);
    chk("pin_up200", 1, 32'(o1_count), 32'h000200);

    // Rollover at 59:59.99
    i_load = 1'b1; i_load_value = 24'h595998;
    cycle();
    i_load = 1'b0;
    chk("pin_ld_max", 1, 32'(o1_count), 32'h595998);
    cycle();
    chk("pin_max", 1, 32'(o1_count), 32'h595999);
    cycle();
    chk("pin_wrap_cnt", 1, 32'(o1_count), 32'h000000);
    chk("pin_wrap_hi", 1, 32'(o1_wrap), 32'd1);
    cycle();
    chk("pin_wrap_lo", 1, 32'(o1_wrap), 32'd0);
    cycles(4);

    // Down count with borrow, then hold at zero
    i_updown = 1'b0; i_load = 1'b1; i_load_value = 24'h010000;
    cycle();
    i_load = 1'b0;
    cycle();
    chk("pin_dn1", 1, 32'(o1_count), 32'h005999);
    cycle();
    chk("pin_dn2", 1, 32'(o1_count), 32'h005998);
    i_load = 1'b1; i_load_value = 24'h000001;
    cycle();
    i_load = 1'b0;
    cycle();
    chk("pin_dn_zero", 1, 32'(o1_count), 32'h000000);
    cycles(10);
    chk("pin_hold", 1, 32'(o1_count), 32'h000000);
    chk("pin_hold_z", 1, 32'(o1_zero), 32'd1);
    chk("pin_hold_z", 0, 32'(o0_zero), 32'd1);

    // Load validation and clear-over-load priority
    i_countenb = 1'b0; i_load = 1'b1; i_load_value = 24'h000500;
    cycle();
    i_load_value = 24'h0A0000;
    cycle();
    chk("pin_lderr", 1, 32'(o1_load_err), 32'd1);
    chk("pin_lderr_cnt", 1, 32'(o1_count), 32'h000500);
    i_load = 1'b0;
    cycle();
    chk("pin_lderr_pulse", 1, 32'(o1_load_err), 32'd0);
    i_load = 1'b1; i_load_value = 24'h123456; i_countinit = 1'b1;
    cycle();
    chk("pin_init_cnt", 0, 32'(o0_count), 32'h0);
    chk("pin_init_err", 0, 32'(o0_load_err), 32'd0);
    i_countinit = 1'b0;

    // Five laps at counts 1..5 into a depth-4 buffer, then drain
    i_load_value = 24'h000001;
    cycle();
    for (int k = 1; k <= 5; k++) begin
      i_lap = 1'b1; i_load_value = 24'(k + 1);
      cycle();
    end
    i_lap = 1'b0; i_load = 1'b0;
    chk("pin_lap_lvl", 0, 32'(o0_lap_level), 32'd4);
    chk("pin_lap_full", 0, 32'(o0_lap_full), 32'd1);
    chk("pin_lap_ovf", 0, 32'(o0_lap_ovf), 32'd1);
    chk("pin_lap_head", 0, 32'(o0_lap_count), 32'h000001);
    i_lap_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      cycle();
      chk("pin_lap_rd", 0, 32'(o0_lap_count), 32'(k));
    end
    cycle();
    chk("pin_lap_empty", 0, 32'(o0_lap_valid), 32'd0);
    chk("pin_lap_zero", 0, 32'(o0_lap_count), 32'h0);
    i_lap_ready = 1'b0;

    // Full buffer with simultaneous push and pop
    i_countinit = 1'b1;
    cycle();
    i_countinit = 1'b0;
    chk("pin_ovf_clr", 0, 32'(o0_lap_ovf), 32'd0);
    i_load = 1'b1; i_load_value = 24'h000001;
    cycle();
    for (int k = 1; k <= 4; k++) begin
      i_lap = 1'b1; i_load_value = 24'(k + 1);
      cycle();
    end
    i_load = 1'b0; i_lap = 1'b1; i_lap_ready = 1'b1;
    cycle();
    i_lap = 1'b0;
    chk("pin_pp_lvl", 0, 32'(o0_lap_level), 32'd4);
    chk("pin_pp_ovf", 0, 32'(o0_lap_ovf), 32'd0);
    chk("pin_pp_head", 0, 32'(o0_lap_count), 32'h000002);
    cycles(3);
    chk("pin_pp_last", 0, 32'(o0_lap_count), 32'h000005);
    cycle();
    chk("pin_pp_empty", 0, 32'(o0_lap_valid), 32'd0);
    i_lap_ready = 1'b0;

    // Reset in the middle of counting and capturing
    i_countenb = 1'b1; i_updown = 1'b1; i_lap = 1'b1;
    cycles(2);
    i_lap = 1'b0;
    cycles(3);
    i_reset = 1'b1;
    cycle();
    chk("pin_mrst_cnt", 0, 32'(o0_count), 32'h0);
    chk("pin_mrst_valid", 0, 32'(o0_lap_valid), 32'd0);
    chk("pin_mrst_lvl", 1, 32'(o1_lap_level), 32'd0);
    i_reset = 1'b0;
    cycle();
    chk("pin_rel1", 0, 32'(o0_count), 32'h000000);
    cycle();
    chk("pin_rel2", 0, 32'(o0_count), 32'h000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
